// File: rtl/keypad_scan_fifo_if.sv
// Keypad scanner bus: matrix lines plus
// the host-side key queue handshake.
interface keypad_scan_fifo_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 3,
  parameter int CODE_W = 6
);
  logic [ROWS-1:0]   ROW_IN;
  logic [COLS-1:0]   COL_OUT;
  logic [CODE_W-1:0] KEY_DATA;
  logic              KEY_VALID;
  logic              KEY_ACK;
  logic              INTERRUPT;
  logic              OVERFLOW;
  logic              CLR_OVF;

  modport master (
    input  ROW_IN,
    input  KEY_ACK,
    input  CLR_OVF,
    output COL_OUT,
    output KEY_DATA,
    output KEY_VALID,
    output INTERRUPT,
    output OVERFLOW
  );

  modport slave (
    output ROW_IN,
    output KEY_ACK,
    output CLR_OVF,
    input  COL_OUT,
    input  KEY_DATA,
    input  KEY_VALID,
    input  INTERRUPT,
    input  OVERFLOW
  );
endinterface

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner with frame debounce
// and a show-ahead key-code queue.
module keypad_scan_fifo #(
  parameter int ROWS       = 4,
  parameter int COLS       = 3,
  parameter int SCAN_DIV   = 2272727,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int CODE_W     = 6
) (
  input logic CLK,
  input logic RST_N,
  keypad_scan_fifo_if.master bus
);
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int COL_W = $clog2(COLS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(SCAN_DIV - 1);
  localparam logic [COL_W-1:0] COL_LAST =
    COL_W'(COLS - 1);
  localparam logic [3:0] DB = 4'(DEBOUNCE);
  localparam logic [LVL_W-1:0] FULL =
    LVL_W'(FIFO_DEPTH);
  localparam logic [CODE_W-1:0] ROWS_C =
    CODE_W'(ROWS);

  typedef enum logic {IDLE, HELD} state_t;

  logic [CNT_W-1:0]  cnt;
  logic [COL_W-1:0]  col_idx;
  logic [COLS-1:0]   col_out;
  logic              tick;
  logic              frame_end;

  logic              acc_found;
  logic [CODE_W-1:0] acc_code;
  logic              cand_found;
  logic [CODE_W-1:0] cand_code;
  logic [3:0]        stable;

  logic [CODE_W-1:0] row_sel;
  logic              hit;
  logic [CODE_W-1:0] cur_code;
  logic              frm_found;
  logic [CODE_W-1:0] frm_code;
  logic              same;
  logic [3:0]        stable_nxt;

  state_t            state;
  state_t            state_nxt;
  logic              push;

  logic [CODE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [LVL_W-1:0]  level;
  logic              valid;
  logic              full;
  logic              do_pop;
  logic              wr_en;
  logic              drop;
  logic              irq;
  logic              ovf;

  assign tick      = (cnt == CNT_MAX);
  assign frame_end = tick && (col_idx == COL_LAST);

  // Column step timer and one-hot column drive.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt     <= '0;
      col_idx <= '0;
      col_out <= COLS'(1);
    end else if (tick) begin
      cnt     <= '0;
      col_idx <= frame_end ? '0 : col_idx + 1'b1;
      col_out <= {col_out[COLS-2:0],
                  col_out[COLS-1]};
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Lowest asserted row of the driven column.
  always_comb begin
    row_sel = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (bus.ROW_IN[r]) row_sel = CODE_W'(r);
    end
  end

  assign hit       = |bus.ROW_IN;
  assign cur_code  = CODE_W'(col_idx) * ROWS_C
                   + row_sel;
  assign frm_found = acc_found | (tick & hit);
  assign frm_code  = acc_found ? acc_code
                               : cur_code;

  assign same = (frm_found == cand_found) &&
                (!frm_found ||
                 frm_code == cand_code);
  assign stable_nxt = !same ? 4'd1 :
                      (stable == DB) ? DB :
                      stable + 4'd1;

  // First key of the frame, then debounce run.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      acc_found  <= 1'b0;
      acc_code   <= '0;
      cand_found <= 1'b0;
      cand_code  <= '0;
      stable     <= '0;
    end else if (frame_end) begin
      acc_found  <= 1'b0;
      cand_found <= frm_found;
      cand_code  <= frm_code;
      stable     <= stable_nxt;
    end else if (tick && !acc_found && hit) begin
      acc_found <= 1'b1;
      acc_code  <= cur_code;
    end
  end

  // Press/release state register.
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Accept on a stable key, re-arm on stable release.
  always_comb begin
    state_nxt = state;
    if (frame_end && stable_nxt == DB) begin
      unique case (state)
        IDLE: if (frm_found)  state_nxt = HELD;
        HELD: if (!frm_found) state_nxt = IDLE;
      endcase
    end
  end

  // Push request for a newly accepted key.
  always_comb begin
    push = frame_end && state == IDLE &&
           frm_found && stable_nxt == DB;
  end

  assign valid  = (level != '0);
  assign full   = (level == FULL);
  assign do_pop = bus.KEY_ACK & valid;
  assign wr_en  = push & (~full | do_pop);
  assign drop   = push & full & ~do_pop;

  // Queue storage; contents are don't-care when empty.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wptr] <= frm_code;
  end

  // Queue pointers, interrupt and sticky overflow.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      irq   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (wr_en)  wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      level <= level + LVL_W'(wr_en)
                     - LVL_W'(do_pop);
      irq   <= wr_en;
      if (drop)             ovf <= 1'b1;
      else if (bus.CLR_OVF) ovf <= 1'b0;
    end
  end

  assign bus.COL_OUT   = col_out;
  assign bus.KEY_VALID = valid;
  assign bus.KEY_DATA  = valid ? mem[rptr] : '0;
  assign bus.INTERRUPT = irq;
  assign bus.OVERFLOW  = ovf;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Random and directed checks of the keypad
// scanner against a frame-level model.
module tb_keypad_scan_fifo;
  localparam int ROWS   = 4;
  localparam int COLS   = 3;
  localparam int DIV    = 4;
  localparam int DB     = 2;
  localparam int DEPTH  = 4;
  localparam int CODE_W = 6;
  localparam int FRAME  = COLS * DIV;
  localparam int NKEY   = ROWS * COLS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_scan_fifo_if #(
    .ROWS(ROWS), .COLS(COLS), .CODE_W(CODE_W)
  ) bus ();

  keypad_scan_fifo #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(DIV),
    .DEBOUNCE(DB), .FIFO_DEPTH(DEPTH),
    .CODE_W(CODE_W)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .bus(bus)
  );

  logic [NKEY-1:0] keys = '0;
  bit all_rows = 1'b1;
  int m_col = 0;

  assign bus.ROW_IN = all_rows ? '1 :
    keys[m_col*ROWS +: ROWS];

  int checks = 0;
  int failures = 0;
  int irq_seen = 0;
  int n = 0;
  int q[$];
  int hist[$];
  bit held = 0;
  bit m_irq = 0;
  bit m_ovf = 0;

  task automatic chk(string tag,
                     logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d",
               tag, got, exp);
    end
  endtask

  // Frame code is the lowest-numbered key held.
  function automatic int frame_code(
    logic [NKEY-1:0] k);
    for (int i = 0; i < NKEY; i++)
      if (k[i]) return i;
    return -1;
  endfunction

  task automatic step(input bit ack,
                      input bit clr);
    int code;
    bit pop, push, drop, steady;
    bus.KEY_ACK = ack;
    bus.CLR_OVF = clr;
    @(posedge clk);
    @(negedge clk);
    if (!rst_n) begin
      n = 0; m_col = 0; held = 0;
      m_irq = 0; m_ovf = 0;
      q.delete(); hist.delete();
    end else begin
      n++;
      pop = ack && q.size() > 0;
      push = 0; drop = 0; code = -1;
      if (n % FRAME == 0) begin
        code = frame_code(keys);
        hist.push_back(code);
        if (hist.size() > DB)
          void'(hist.pop_front());
        steady = (hist.size() == DB);
        foreach (hist[i])
          if (hist[i] != code) steady = 0;
        if (steady && !held && code >= 0) begin
          push = 1; held = 1;
        end else if (steady && held && code < 0)
          held = 0;
      end
      if (pop) void'(q.pop_front());
      m_irq = 0;
      if (push) begin
        if (q.size() < DEPTH) begin
          q.push_back(code); m_irq = 1;
        end else drop = 1;
      end
      if (drop)     m_ovf = 1;
      else if (clr) m_ovf = 0;
      if (n % DIV == 0) m_col = (m_col + 1) % COLS;
    end
    if (bus.INTERRUPT === 1'b1) irq_seen++;
    chk("col_out", bus.COL_OUT, 1 << m_col);
    chk("key_valid", bus.KEY_VALID, q.size() > 0);
    chk("key_data", bus.KEY_DATA,
        q.size() > 0 ? q[0] : 0);
    chk("interrupt", bus.INTERRUPT, m_irq);
    chk("overflow", bus.OVERFLOW, m_ovf);
  endtask

  task automatic do_reset(int cyc, bit rows_hi);
    rst_n = 0;
    all_rows = rows_hi;
    keys = '0;
    repeat (cyc) step(0, 0);
    rst_n = 1;
    all_rows = 0;
    irq_seen = 0;
  endtask

  task automatic frames(int nf,
                        logic [NKEY-1:0] k);
    keys = k;
    repeat (nf) begin
      do step(0, 0); while (n % FRAME != 0);
    end
  endtask

  task automatic key(int c, int hold);
    frames(hold, NKEY'(1) << c);
  endtask

  initial begin
    bus.KEY_ACK = 0;
    bus.CLR_OVF = 0;

    do_reset(3, 1);
    chk("rst_col", bus.COL_OUT, 3'b001);
    chk("rst_valid", bus.KEY_VALID, 0);
    chk("rst_irq", bus.INTERRUPT, 0);
    chk("rst_ovf", bus.OVERFLOW, 0);
    repeat (DIV) step(0, 0);
    chk("scan_c1", bus.COL_OUT, 3'b010);
    repeat (DIV) step(0, 0);
    chk("scan_c2", bus.COL_OUT, 3'b100);
    repeat (DIV) step(0, 0);
    chk("scan_wrap", bus.COL_OUT, 3'b001);

    do_reset(2, 0);
    key(6, 2);
    chk("single_irq", irq_seen, 1);
    chk("single_data", bus.KEY_DATA, 6);
    chk("single_valid", bus.KEY_VALID, 1);
    step(1, 0);
    chk("single_ack", bus.KEY_VALID, 0);

    do_reset(2, 0);
    key(6, 1); frames(1, '0); key(6, 1);
    chk("bounce_early", irq_seen, 0);
    key(6, 1);
    chk("bounce_push", irq_seen, 1);
    key(6, 11);
    frames(3, NKEY'(12'h240));
    chk("bounce_hold", irq_seen, 1);

    do_reset(2, 0);
    key(6, 2); frames(1, '0); key(6, 3);
    chk("rearm_short", irq_seen, 1);
    frames(2, '0); key(6, 2);
    chk("rearm_long", irq_seen, 2);

    do_reset(2, 0);
    for (int c = 0; c < 5; c++) begin
      key(c, 2); frames(2, '0);
    end
    chk("ovf_irqs", irq_seen, 4);
    chk("ovf_flag", bus.OVERFLOW, 1);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_order", bus.KEY_DATA, i);
      step(1, 0);
    end
    chk("ovf_empty", bus.KEY_VALID, 0);
    step(0, 1);
    chk("ovf_clr", bus.OVERFLOW, 0);

    do_reset(2, 0);
    for (int c = 0; c < 4; c++) begin
      key(c, 2); frames(2, '0);
    end
    key(5, 1);
    repeat (FRAME - 1) step(0, 0);
    step(1, 0);
    chk("sim_irqs", irq_seen, 5);
    chk("sim_ovf", bus.OVERFLOW, 0);
    for (int i = 0; i < 4; i++) begin
      chk("sim_order", bus.KEY_DATA,
          i < 3 ? i + 1 : 5);
      step(1, 0);
    end
    chk("sim_empty", bus.KEY_VALID, 0);

    do_reset(2, 0);
    keys = NKEY'(1) << 7;
    repeat (FRAME + 5) step(0, 0);
    do_reset(2, 0);
    key(7, 1); frames(3, '0);
    chk("mid_rst_irq", irq_seen, 0);
    chk("mid_rst_valid", bus.KEY_VALID, 0);

    do_reset(2, 0);
    for (int f = 0; f < 150; f++) begin
      int r;
      int hold;
      logic [NKEY-1:0] k;
      r = $urandom_range(0, 9);
      k = '0;
      if (r >= 5)
        k[$urandom_range(0, NKEY - 1)] = 1'b1;
      if (r == 9)
        k[$urandom_range(0, NKEY - 1)] = 1'b1;
      keys = k;
      hold = $urandom_range(1, 4);
      repeat (hold) begin
        do step($urandom_range(0, 3) == 0,
                $urandom_range(0, 19) == 0);
        while (n % FRAME != 0);
      end
      if (f == 90) begin
        keys = NKEY'(1) << 3;
        repeat ($urandom_range(1, 20))
          step(0, 0);
        do_reset(2, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
